mult_iter_param: RTL and testbench
==================================

// Module: mult_iter_param
// PURPOSE
//  Parametrised iterative shift-add multiplier, successor to the fixed 32-bit unsigned multiply unit.
//  Adds a run-time signed/unsigned mode, abort-on-drop of mult_begin, an optional early-exit and a busy flag.
//  Sits beside the ALU in the CPU datapath; the pipeline holds mult_begin high until mult_end.
// PARAMETERS
//  WIDTH       32  operand width in bits; product is 2*WIDTH; legal range 4..64
//  EARLY_EXIT  0   1: finish as soon as the remaining multiplier bits are all zero
// PORTS
//  clk          in   1        single clock, rising edge
//  resetn       in   1        asynchronous active-low reset
//  mult_begin   in   1        level request; must stay high for the whole operation
//  mult_signed  in   1        1: two's-complement operands; 0: unsigned; sampled at capture only
//  mult_op1     in   WIDTH    multiplicand; sampled at capture only
//  mult_op2     in   WIDTH    multiplier; sampled at capture only
//  product      out  2*WIDTH  result; valid while mult_end=1; held until next result write
//  mult_end     out  1        registered done flag
//  mult_busy    out  1        high while in BUSY
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, product=0, mult_end=0, mult_busy=0, counter=0.
//  FSM states IDLE, BUSY, DONE. All transitions occur on the rising edge of clk.
//   - IDLE & mult_begin=1: capture operands -> BUSY, count=0.
//     Captured values: |op1| into a 2*WIDTH multiplicand register and |op2| into a WIDTH multiplier register.
//     Magnitudes are taken only if mult_signed=1; a neg flag is stored as op1[MSB]^op2[MSB] in signed mode, else 0.
//   - BUSY & mult_begin=1: if mcand_lsb... per edge, if multiplier[0] then acc += mcand.
//     Then mcand <<= 1, multiplier >>= 1, count++.
//     The last iteration is count==WIDTH-1, or, when EARLY_EXIT=1, the first edge at which the shifted multiplier is 0.
//     On the last iteration: product <= neg ? -(acc_next) : acc_next, and state -> DONE.
//   - BUSY & mult_begin=0: abort -> IDLE; product and mult_end are unchanged (mult_end is already 0).
//   - DONE: mult_end=1; stays in DONE while mult_begin=1.
//     mult_begin=0 -> IDLE with mult_end=0 on that edge.
//     A new operation therefore needs mult_begin low for at least 1 cycle.
//  Latency (EARLY_EXIT=0): mult_end rises WIDTH+1 edges after the capture edge (33 for WIDTH=32).
//  With EARLY_EXIT=1: 1 + (index of highest set bit of |op2|) + 1 edges; minimum 2 edges when |op2|<=1.
//  Width rules:
//   - acc and mcand are 2*WIDTH bits; magnitude |x| is an unsigned WIDTH-bit value, so |0x80..0| = 2^(WIDTH-1) is exact.
//   - Negation is modulo 2^(2*WIDTH).
//  mult_busy = (state==BUSY); mult_end = (state==DONE); both are decoded from registered state, glitch-free.
//  Operand changes during BUSY/DONE are ignored. Reset mid-operation returns to reset values immediately.
//  Zero operand: result 0, neg forced irrelevant (-0 = 0).
// STRUCTURE
//  Shared header mult_defs.vh: state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2.
//   Encoding 2'd3 is illegal and decodes to IDLE.
//  Sub-module mult_abs #(W): combinational conditional two's-complement out = neg ? -in : in.
//   Instantiated for op1 (W=WIDTH), op2 (W=WIDTH) and the final result (W=2*WIDTH).
//  Counter width $clog2(WIDTH).
// TESTING
//  1 unsigned, op1=0xF0000000, op2=0x00000002, begin held
//    -> mult_end at edge 33, product=0x00000001E0000000.
//  2 signed, same operands
//    -> product=0xFFFFFFFFE0000000; signed 0x80000000*0x80000000 -> 0x4000000000000000.
//  3 signed -1*-1 (0xFFFFFFFF each)
//    -> 0x0000000000000001; unsigned -> 0xFFFFFFFE00000001.
//  4 drop mult_begin at edge 10 of BUSY
//    -> IDLE next edge, mult_end never rises, product keeps previous result.
//  5 resetn low at edge 15 of BUSY
//    -> product=0, mult_end=0, mult_busy=0 immediately; begin held after release restarts cleanly.
//  6 EARLY_EXIT=1, op2=3, op1=7
//    -> mult_end after 3 edges, product=21; 200 random signed/unsigned pairs match a $signed/$unsigned reference model.

Source files
------------

// File: rtl/mult_iter_param_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// Holds the FSM state encoding. Encoding 2'd3 is unused; the FSM treats it as IDLE.
package mult_iter_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_abs.sv
// Conditional two's-complement negation: result = neg ? -value : value.
// Used for operand magnitudes and for re-applying the sign to the product.
// Ports:
//   neg    in   1   negate when high
//   value  in   W   operand
//   result out  W   value or its negation, modulo 2^W
module mult_abs
  import mult_iter_param_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] value,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/mult_iter_param.sv
// Iterative shift-add multiplier with run-time signed/unsigned mode,
// abort when mult_begin drops, optional early exit and a busy flag.
// Operands are reduced to magnitudes at capture; the sign is re-applied
// to the final accumulator value when the last iteration is taken.
// Ports:
//   clk          in   1        rising-edge clock
//   resetn       in   1        asynchronous active-low reset
//   mult_begin   in   1        level request, held high for the whole operation
//   mult_signed  in   1        1: two's-complement operands (sampled at capture)
//   mult_op1     in   WIDTH    multiplicand (sampled at capture)
//   mult_op2     in   WIDTH    multiplier (sampled at capture)
//   product      out  2*WIDTH  result, held until the next result write
//   mult_end     out  1        high in DONE
//   mult_busy    out  1        high in BUSY
module mult_iter_param
  import mult_iter_param_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               mult_begin,
  input  logic               mult_signed,
  input  logic [WIDTH-1:0]   mult_op1,
  input  logic [WIDTH-1:0]   mult_op2,
  output logic [2*WIDTH-1:0] product,
  output logic               mult_end,
  output logic               mult_busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic               capture, step, last;

  logic [WIDTH-1:0]   op1_mag, op2_mag;
  logic [2*WIDTH-1:0] mcand, acc, acc_next, result;
  logic [WIDTH-1:0]   mplier, mplier_next;
  logic               neg;

  mult_abs #(.W(WIDTH)) u_abs_op1 (
    .neg    (mult_signed & mult_op1[WIDTH-1]),
    .value  (mult_op1),
    .result (op1_mag)
  );

  mult_abs #(.W(WIDTH)) u_abs_op2 (
    .neg    (mult_signed & mult_op2[WIDTH-1]),
    .value  (mult_op2),
    .result (op2_mag)
  );

  mult_abs #(.W(2*WIDTH)) u_abs_res (
    .neg    (neg),
    .value  (acc_next),
    .result (result)
  );

  assign acc_next    = mplier[0] ? (acc + mcand) : acc;
  assign mplier_next = mplier >> 1;
  // Early exit looks at the multiplier after this edge's shift: once no set
  // bits remain, further iterations cannot change the accumulator.
  assign last        = (cnt == CNT_W'(WIDTH - 1)) ||
                       (EARLY_EXIT && (mplier_next == '0));

  always_comb begin
    state_next = ST_IDLE;
    capture    = 1'b0;
    step       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mult_begin) begin
          state_next = ST_BUSY;
          capture    = 1'b1;
        end
      end
      ST_BUSY: begin
        if (mult_begin) begin
          step       = 1'b1;
          state_next = last ? ST_DONE : ST_BUSY;
        end
      end
      ST_DONE: begin
        state_next = mult_begin ? ST_DONE : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        cnt <= '0;
      end else if (step) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (step && last) begin
        product <= result;
      end
    end
  end

  // Working registers are only meaningful between capture and the last step,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      mcand  <= {{WIDTH{1'b0}}, op1_mag};
      mplier <= op2_mag;
      acc    <= '0;
      neg    <= mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier_next;
    end
  end

  assign mult_busy = (state == ST_BUSY);
  assign mult_end  = (state == ST_DONE);

endmodule

// File: tb/tb_mult_iter_param.sv
// Directed and random checks for mult_iter_param, run on two instances
// sharing stimulus: dut0 without early exit, dut1 with early exit.
module tb_mult_iter_param;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           resetn;
  logic           mult_begin;
  logic           mult_signed;
  logic [W-1:0]   op1, op2;
  logic [2*W-1:0] product0, product1;
  logic           end0, end1, busy0, busy1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_iter_param #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
    .clk         (clk),
    .resetn      (resetn),
    .mult_begin  (mult_begin),
    .mult_signed (mult_signed),
    .mult_op1    (op1),
    .mult_op2    (op2),
    .product     (product0),
    .mult_end    (end0),
    .mult_busy   (busy0)
  );

  mult_iter_param #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
    .clk         (clk),
    .resetn      (resetn),
    .mult_begin  (mult_begin),
    .mult_signed (mult_signed),
    .mult_op1    (op1),
    .mult_op2    (op2),
    .product     (product1),
    .mult_end    (end1),
    .mult_busy   (busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Edges to mult_end for the early-exit instance, counting the capture edge.
  function automatic int ee_lat(input logic sgn, input logic [W-1:0] b);
    logic [W-1:0] m;
    int hb;
    m  = (sgn && b[W-1]) ? (~b + 32'd1) : b;
    hb = 0;
    for (int i = 0; i < W; i++) begin
      if (m[i]) hb = i;
    end
    return hb + 2;
  endfunction

  // Starts an operation, scrambles the operands after capture, measures the
  // edge at which each instance raises mult_end and checks both results.
  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [63:0] exp, input int lat1);
    int e0;
    int e1;
    e0 = 0;
    e1 = 0;
    mult_signed = sgn;
    op1         = a;
    op2         = b;
    mult_begin  = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 1) begin
        chk({tag, "_busy"}, 64'(busy0), 64'd1);
        op1         = ~a;
        op2         = ~b;
        mult_signed = ~sgn;
      end
      if (e0 == 0 && end0) e0 = e;
      if (e1 == 0 && end1) e1 = e;
      if (e0 != 0 && e1 != 0) break;
    end
    chk({tag, "_lat0"}, 64'(e0), 64'd33);
    chk({tag, "_lat1"}, 64'(e1), 64'(lat1));
    chk({tag, "_prod0"}, product0, exp);
    chk({tag, "_prod1"}, product1, exp);
    mult_begin = 1'b0;
    tick();
    chk({tag, "_end_clr"}, {62'd0, end0, end1}, 64'd0);
  endtask

  initial begin
    logic [63:0] ref_p;
    logic [W-1:0] a, b;
    logic         s;
    longint       sa, sb;

    resetn      = 1'b0;
    mult_begin  = 1'b0;
    mult_signed = 1'b0;
    op1         = '0;
    op2         = '0;
    tick();
    tick();
    chk("rst_prod", product0, 64'd0);
    chk("rst_flags", {60'd0, end0, busy0, end1, busy1}, 64'd0);
    resetn = 1'b1;
    tick();
    chk("idle_flags", {60'd0, end0, busy0, end1, busy1}, 64'd0);

    run_op("t1_unsigned", 1'b0, 32'hF0000000, 32'h00000002, 64'h00000001E0000000, 3);
    run_op("t2_signed", 1'b1, 32'hF0000000, 32'h00000002, 64'hFFFFFFFFE0000000, 3);
    run_op("t2_minmin", 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 33);
    run_op("t3_signed", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 2);
    run_op("zero_u", 1'b0, 32'h00001234, 32'h00000000, 64'd0, 2);
    run_op("zero_s", 1'b1, 32'hFFFFFFFB, 32'h00000000, 64'd0, 2);
    run_op("t3_unsigned", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 33);

    // Abort: drop mult_begin after the tenth edge of the operation.
    mult_signed = 1'b0;
    op1         = 32'd5;
    op2         = 32'hFFFFFFFF;
    mult_begin  = 1'b1;
    repeat (10) tick();
    chk("abort_busy", {62'd0, busy0, busy1}, 64'd3);
    mult_begin = 1'b0;
    tick();
    chk("abort_idle", {60'd0, end0, busy0, end1, busy1}, 64'd0);
    chk("abort_prod0", product0, 64'hFFFFFFFE00000001);
    chk("abort_prod1", product1, 64'hFFFFFFFE00000001);
    repeat (5) tick();
    chk("abort_no_end", {62'd0, end0, end1}, 64'd0);

    // Asynchronous reset in the middle of an operation.
    mult_signed = 1'b1;
    op1         = 32'hFFFFFFFD;
    op2         = 32'd7;
    mult_begin  = 1'b1;
    repeat (15) tick();
    chk("mid_busy", 64'(busy0), 64'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_prod0", product0, 64'd0);
    chk("mid_rst_prod1", product1, 64'd0);
    chk("mid_rst_flags", {60'd0, end0, busy0, end1, busy1}, 64'd0);
    tick();
    resetn = 1'b1;
    run_op("restart", 1'b1, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFFFFFFFFEB, 4);

    run_op("t6_early", 1'b0, 32'd7, 32'd3, 64'd21, 3);

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) b = 32'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      if (s) begin
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        ref_p = 64'(sa * sb);
      end else begin
        ref_p = {32'd0, a} * {32'd0, b};
      end
      run_op("rand", s, a, b, ref_p, ee_lat(s, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
